// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with a 2-bit predictor state per entry.
// Lookup is combinational from the registered table; updates come from the
// resolved branch in EX and land on the next rising clock edge.
// Optional feature: define BTB_BYPASS_EN to forward a same-cycle update
// to the lookup port when it targets the same index and tag.
module branch_target_buffer #(
    parameter int XLEN  = 32,
    parameter int IDX_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] lookup_pc,
    output logic            lookup_hit,
    output logic [1:0]      lookup_state,
    output logic            pred_taken,
    output logic [XLEN-1:0] next_pc,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target,
    input  logic [1:0]      upd_state,
    input  logic            flush_all
);

    localparam int ENTRIES = 1 << IDX_W;
    localparam int TAG_W   = XLEN - IDX_W - 2;

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [XLEN-1:0]   target;
        logic [1:0]        state;
    } entry_t;

    entry_t table_q [ENTRIES];

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;
    logic             up_hit;
    logic             up_write;
    entry_t           rd_entry;
    logic             rd_hit;

    // Instructions are word aligned; the byte-offset bits of the update PC
    // carry no information for indexing or tagging.
    logic unused_upd_pc_bits;
    assign unused_upd_pc_bits = ^upd_pc[1:0];

    assign lk_idx = lookup_pc[IDX_W+1:2];
    assign lk_tag = lookup_pc[XLEN-1:IDX_W+2];
    assign up_idx = upd_pc[IDX_W+1:2];
    assign up_tag = upd_pc[XLEN-1:IDX_W+2];

    // A resolved branch writes when it refreshes its own entry, or when it
    // was taken and must claim the slot; a flush suppresses any write.
    assign up_hit   = table_q[up_idx].valid && (table_q[up_idx].tag == up_tag);
    assign up_write = upd_valid && !flush_all && (up_hit || upd_taken);

    // Table state: async clear, flush of valid bits, or a single entry write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the whole table is reset, not just the valid bits, so
            // tags/targets/states come out of reset at a known zero value.
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i] <= '0;
            end
        end else if (flush_all) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i].valid <= 1'b0;
            end
        end else if (up_write) begin
            // NOTE: non-blocking assignments keep the same-cycle lookup
            // reading pre-update contents regardless of process ordering.
            table_q[up_idx].valid <= 1'b1;
            table_q[up_idx].tag   <= up_tag;
            table_q[up_idx].state <= upd_state;
            if (upd_taken) begin
                table_q[up_idx].target <= upd_target;
            end
        end
    end

    // Read the indexed entry, optionally overlaid with the in-flight update.
    always_comb begin
        // NOTE: rd_entry is fully assigned before any conditional override,
        // so no latch is inferred on the paths that skip the bypass.
        rd_entry = table_q[lk_idx];
`ifdef BTB_BYPASS_EN
        if (rst && up_write && (up_idx == lk_idx) && (up_tag == lk_tag)) begin
            rd_entry.valid = 1'b1;
            rd_entry.tag   = up_tag;
            rd_entry.state = upd_state;
            if (upd_taken) begin
                rd_entry.target = upd_target;
            end
        end
`endif
        rd_hit = rd_entry.valid && (rd_entry.tag == lk_tag);
    end

    // Prediction outputs; a miss reports strong-not-taken and falls through.
    always_comb begin
        lookup_hit   = rd_hit;
        lookup_state = rd_hit ? rd_entry.state : 2'b00;
        pred_taken   = rd_hit && rd_entry.state[1];
        next_pc      = pred_taken ? rd_entry.target : lookup_pc + XLEN'(4);
    end

endmodule

// File: doc/branch_target_buffer.md
BRANCH_TARGET_BUFFER -- requirements
Module: branch_target_buffer

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, the PC and target width.
REQ-002 The block SHALL have parameter IDX_W, default 5, the index width (2**IDX_W = 32 entries).
REQ-003 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst  input  1  the reset: asynchronous, active-low.
REQ-005 The block SHALL have port lookup_pc  input  XLEN  the fetch-stage PC.
REQ-006 The block SHALL have port lookup_hit  output  1  the valid entry whose tag matches lookup_pc.
REQ-007 The block SHALL have port lookup_state  output  2  the 2-bit predictor state fed to the predictor FSM (00 strong_nt, 01 weak_nt, 10 weak_t, 11 strong_t).
REQ-008 The block SHALL have port pred_taken  output  1  lookup_hit AND lookup_state[1].
REQ-009 The block SHALL have port next_pc  output  XLEN  the stored target if pred_taken, else lookup_pc+4.
REQ-010 The block SHALL have port upd_valid  input  1  the resolved branch from EX.
REQ-011 The block SHALL have port upd_pc  input  XLEN  the resolved branch PC.
REQ-012 The block SHALL have port upd_taken  input  1  the actual branch outcome.
REQ-013 The block SHALL have port upd_target  input  XLEN  the resolved target.
REQ-014 The block SHALL have port upd_state  input  2  the next state produced by the predictor FSM.
REQ-015 The block SHALL have port flush_all  input  1  invalidates all entries (fence.i).

Function
REQ-016 Index SHALL be pc[IDX_W+1:2] and tag SHALL be pc[XLEN-1:IDX_W+2] (25 bits at defaults); each entry holds valid, tag, target, state.
REQ-017 Lookup SHALL be combinational from registered table contents: zero-cycle latency.
REQ-018 On lookup miss, lookup_state SHALL be 2'b00, pred_taken 0, and next_pc lookup_pc+4 (modulo 2**XLEN, wrapping).
REQ-019 On upd_valid with tag hit, the entry's state SHALL become upd_state at the next edge; its target SHALL become upd_target only if upd_taken=1.
REQ-020 On upd_valid with miss and upd_taken=1, the entry SHALL be (re)allocated: valid=1, new tag, target=upd_target, state=upd_state, evicting any previous occupant.
REQ-021 On upd_valid with miss and upd_taken=0, the table SHALL NOT change.
REQ-022 Update writes SHALL become visible to lookup one cycle after the update edge (lookup and update on the same index in the same cycle return pre-update contents) unless BTB_BYPASS_EN is defined.
REQ-023 flush_all=1 SHALL clear every valid bit at the next edge; if upd_valid is also 1 in that cycle, flush SHALL win and no allocation occurs.
REQ-024 upd_valid=0 SHALL leave the table unchanged; the table SHALL hold contents indefinitely without updates.

Reset
REQ-025 rst=0 SHALL immediately, without a clock, clear all valid bits, states to 2'b00, targets and tags to 0.
REQ-026 Reset asserted mid-operation SHALL abort any update in that cycle; during reset lookup_hit=0, pred_taken=0, next_pc=lookup_pc+4.
REQ-027 First update accepted SHALL be at the first rising clk edge after rst deasserts.

Configuration
REQ-028 With macro BTB_BYPASS_EN defined, a same-cycle upd_valid write to the index and tag of lookup_pc SHALL be forwarded combinationally to lookup_hit/lookup_state/pred_taken/next_pc (flush_all=1 suppresses forwarding); without it, lookup SHALL see only registered contents.

Verification
REQ-029 Reset, then lookup_pc=0x0000_1000 -> lookup_hit=0, lookup_state=00, next_pc=0x0000_1004.
REQ-030 Update pc=0x1000 taken target=0x2000 state=01; next cycle lookup 0x1000 -> hit=1, state=01, pred_taken=0, next_pc=0x1004; update again state=11 -> pred_taken=1, next_pc=0x2000.
REQ-031 Alias: entry at 0x1000 valid, lookup 0x1080 (same index, different tag) -> hit=0; update 0x1080 not-taken -> entry for 0x1000 unchanged.
REQ-032 Same-cycle update and lookup of 0x1000 -> without BTB_BYPASS_EN old state returned, with BTB_BYPASS_EN new state returned.
REQ-033 flush_all and upd_valid in same cycle -> all lookups miss next cycle; rst pulsed low mid-run between edges -> outputs miss immediately.
REQ-034 lookup_pc=0xFFFF_FFFC miss -> next_pc=0x0000_0000.
